// File: rtl/icache_responder_if.sv
// Fetch-side and refill-side bus bundle for icache_responder.
// Ports (signals):
//   ireq          fetch request {valid, addr[63:0]}
//   iresp         fetch response {addr_ok, data_ok, data[31:0]}
//   flush         invalidate all cache lines
//   mem_req_*     line-refill request handshake
//   mem_r*        refill beats from backing memory
// Modports: master = fetch stage / memory model side, slave = responder side.
interface icache_responder_if;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        flush;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;

  modport master (
    output ireq, flush, mem_req_ready, mem_rvalid, mem_rdata, mem_rlast,
    input  iresp, mem_req_valid, mem_req_addr
  );

  modport slave (
    input  ireq, flush, mem_req_ready, mem_rvalid, mem_rdata, mem_rlast,
    output iresp, mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache responding to single-word fetches.
// Hits answer one cycle after acceptance; misses refill a full line from
// the backing memory port (ascending beats from offset 0) and then answer.
// Ports:
//   clk    clock, all state updates on posedge
//   reset  synchronous active-high reset
//   bus    icache_responder_if.slave (fetch request/response, flush, refill port)
module icache_responder #(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  icache_responder_if.slave  bus
);

  localparam int unsigned OFF  = $clog2(LINE_WORDS * 4);
  localparam int unsigned IDX  = $clog2(NUM_LINES);
  localparam int unsigned TAG  = 64 - OFF - IDX;
  localparam int unsigned WOFF = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {IDLE, REQ, REFILL, RESP} state_t;

  state_t              state;
  logic [NUM_LINES-1:0] valid;
  logic [TAG-1:0]      tag_arr  [NUM_LINES];
  logic [31:0]         data_arr [NUM_LINES][LINE_WORDS];

  logic [TAG-1:0]      req_tag;
  logic [IDX-1:0]      req_idx;
  logic [WOFF-1:0]     req_off;
  logic [WOFF-1:0]     cnt;
  logic                flush_pend;

  logic                data_ok_q;
  logic [31:0]         data_q;
  logic                mem_req_valid_q;
  logic [63:0]         mem_req_addr_q;

  // Address decode of the incoming request; byte offset bits are don't-care.
  logic [TAG-1:0]  in_tag;
  logic [IDX-1:0]  in_idx;
  logic [WOFF-1:0] in_off;
  logic            in_hit;
  logic            unused_byte_bits;

  assign in_tag = bus.ireq.addr[63 -: TAG];
  assign in_idx = bus.ireq.addr[OFF +: IDX];
  assign in_off = bus.ireq.addr[2 +: WOFF];
  assign in_hit = valid[in_idx] && (tag_arr[in_idx] == in_tag);
  assign unused_byte_bits = ^bus.ireq.addr[1:0];

  // Response/refill outputs; addr_ok is the only combinational one.
  always_comb begin
    bus.iresp         = '0;
    bus.iresp.addr_ok = (state == IDLE);
    bus.iresp.data_ok = data_ok_q;
    bus.iresp.data    = data_q;
    bus.mem_req_valid = mem_req_valid_q;
    bus.mem_req_addr  = mem_req_addr_q;
  end

  // Controller: lookup, refill sequencing, deferred flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      valid           <= '0;
      data_ok_q       <= 1'b0;
      data_q          <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      cnt             <= '0;
      flush_pend      <= 1'b0;
      req_tag         <= '0;
      req_idx         <= '0;
      req_off         <= '0;
    end else begin
      data_ok_q <= 1'b0;
      case (state)
        IDLE: begin
          // Lookup uses pre-flush valid bits; a same-cycle flush lands after.
          if (bus.ireq.valid) begin
            if (in_hit) begin
              data_ok_q <= 1'b1;
              data_q    <= data_arr[in_idx][in_off];
            end else begin
              req_tag         <= in_tag;
              req_idx         <= in_idx;
              req_off         <= in_off;
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= {in_tag, in_idx, OFF'(0)};
              state           <= REQ;
            end
          end
          if (bus.flush) valid <= '0;
        end
        REQ: begin
          if (bus.flush) flush_pend <= 1'b1;
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            cnt             <= '0;
            state           <= REFILL;
          end
        end
        REFILL: begin
          if (bus.flush) flush_pend <= 1'b1;
          if (bus.mem_rvalid) begin
            data_arr[req_idx][cnt] <= bus.mem_rdata;
            cnt                    <= cnt + WOFF'(1);
            if (bus.mem_rlast) begin
              valid[req_idx]   <= 1'b1;
              tag_arr[req_idx] <= req_tag;
              state            <= RESP;
            end
          end
        end
        RESP: begin
          // Line is complete in the array; answer from it, then apply any flush.
          data_ok_q <= 1'b1;
          data_q    <= data_arr[req_idx][req_off];
          state     <= IDLE;
          if (flush_pend || bus.flush) begin
            valid      <= '0;
            flush_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-bus responder on the far side of the fetch stage's ibus_req_t/ibus_resp_t interface.
- Accepts single-word fetch requests and serves hits from a small direct-mapped instruction cache.
- On a miss, refills a whole line from a backing word-wide memory port, then answers.
- Sits between the fetch stage and the memory/bus arbiter.

Parameters:
- NUM_LINES, 16, number of direct-mapped lines; power of 2, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, at least 2.
- Derived: OFF = log2(LINE_WORDS*4), IDX = log2(NUM_LINES), TAG = 64-OFF-IDX.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ireq  in  ibus_req_t  fetch request; uses valid and addr (u64).
- iresp  out  ibus_resp_t  response; addr_ok, data_ok, data (u32).
- flush  in  1  invalidate all lines (fence.i).
- mem_req_valid  out  1  line-refill request.
- mem_req_addr  out  64  line-aligned refill address (low OFF bits zero).
- mem_req_ready  in  1  memory accepts the refill request.
- mem_rvalid  in  1  refill beat valid.
- mem_rdata  in  32  refill word; beats arrive in ascending word order from offset 0.
- mem_rlast  in  1  final refill beat.

Behaviour:
- Storage: per line, a valid bit, a TAG-bit tag and LINE_WORDS words. addr[OFF-1:2] selects the word; addr[1:0] is ignored.
- Reset: valid bits all 0, state IDLE, iresp.data_ok=0, iresp.data=0, mem_req_valid=0, beat counter 0. Reset mid-refill abandons the refill, leaves the line invalid and ignores any later beats.
- iresp.addr_ok = (state==IDLE), combinational.
- Requester protocol: ireq.addr is held stable from the accepting edge until the cycle data_ok=1. ireq.valid may drop after acceptance; the response is still delivered.
- FSM states: IDLE, REQ, REFILL, RESP.
- IDLE with ireq.valid=1 and a hit:
  - data_ok=1 and data=word in the next cycle (registered, 1-cycle latency).
  - Stay in IDLE; back-to-back hits are served every cycle.
- IDLE with ireq.valid=1 and a miss:
  - Latch the address and go to REQ. data_ok=0 in the next cycle.
- REQ:
  - mem_req_valid=1, mem_req_addr={tag,idx,OFF'b0}.
  - On mem_req_ready=1, go to REFILL and clear the beat counter.
- REFILL:
  - On each mem_rvalid beat, write mem_rdata into word[counter] and increment the counter.
  - On a beat with mem_rlast=1, set valid and tag and go to RESP.
- RESP:
  - data_ok=1 for exactly one cycle with the requested word. The word may come from the line array or be captured during refill.
  - Return to IDLE. No request is accepted in RESP (addr_ok=0).
- data_ok is a single-cycle pulse per accepted request. data holds its last value when data_ok=0.
- flush:
  - In IDLE, clears all valid bits at the edge.
  - A request accepted in the same cycle as flush is evaluated against the pre-flush state: a hit responds normally, a miss refills normally.
  - During REQ, REFILL or RESP, flush is recorded as pending and applied on the edge leaving RESP. The in-flight response still returns the refilled data; afterwards all lines are invalid, including the just-refilled one.
- Refill of index i overwrites whatever tag was previously held at i.
- Beats arriving outside REFILL are ignored.

Test Plan:
- Reset, then ireq addr=0x8000_0000 with memory returning words 0x13,0x93,0x113,0x193 (mem_req_ready=1 at once):
  - mem_req_addr=0x8000_0000.
  - Four beats, then data_ok=1 with data=0x13.
  - Latency is 3 cycles plus the beat count.
- Next request 0x8000_0008 → hit, data_ok=1 next cycle with data=0x113, no mem_req_valid.
- Back-to-back hits 0x8000_0000, 0x8000_0004, 0x8000_000C → data_ok on three consecutive cycles with 0x13, 0x93, 0x193.
- Conflict miss at 0x8000_0100 (same index, NUM_LINES=16):
  - Refill occurs.
  - A subsequent 0x8000_0000 misses again and mem_req_addr=0x8000_0000.
- flush asserted during REFILL:
  - Current response returns the correct data.
  - Re-requesting the same address then misses.
- mem_req_ready held 0 for 5 cycles → mem_req_valid stays 1 with a stable address, addr_ok=0, no data_ok.
- Reset asserted mid-REFILL → all outputs return to reset values. The next fetch to the same line misses.
